clk_ratio_detector: RTL and testbench
=====================================

Name: clk_ratio_detector

Overview:
Measures an incoming divided or slow clock (clk_in) against the system clock clk. It reports the period and high-phase length in clk cycles, flags symmetric duty, and asserts lock once the measured ratio is stable. It is the checking end for the team's clock dividers: it runs in self-test and monitors generated clocks in the clock-management area.

Parameters:
MAX_N, 256, largest measurable period in clk cycles; must be >= 2
LOCK_CNT, 2, consecutive matching measurements required to assert locked; must be >= 1
SYNC_STAGES, 2, synchronizer flop depth on clk_in; must be >= 2
(local) CNT_W = $clog2(MAX_N+1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; same effect as reset except synchronizer flops
clk_in  input  1  clock under test, asynchronous to clk
period  output  CNT_W  last measured rise-to-rise period in clk cycles
high_len  output  CNT_W  high-phase length belonging to that period
meas_valid  output  1  one-cycle pulse when period/high_len update
symmetric  output  1  1 when 2*high_len == period, updated with meas_valid
locked  output  1  ratio stable
timeout  output  1  sticky: no rise seen within MAX_N cycles

Behaviour:
Reset and clock:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0, synchronizer 0, state IDLE, cnt 0, match count 0.

Sampling and edge detect:
- clk_in passes through SYNC_STAGES flops to give s; s_d is s delayed by one cycle.
- rise = s & ~s_d; fall = ~s & s_d. Both are combinational, on the detect cycle.

Counter cnt (CNT_W bits):
- On rise: cnt <= 1.
- Otherwise: cnt <= cnt+1, saturating at MAX_N.
- At a rise, cnt equals the cycles since the previous rise.
- Synchronizer latency is constant, so it does not bias period.

High-phase capture:
- On fall in state ARMED/MEAS/LOCKED, hi_cap <= cnt.
- A fall in IDLE is ignored.

FSM states:
- IDLE: wait for the first rise, then go to ARMED; no measurement is produced.
- ARMED: on rise, produce a measurement and go to MEAS; match count is 0.
- MEAS: on rise, produce a measurement. If it equals the previous measurement (period and high), match count +1, else match count = 0. When match count reaches LOCK_CNT, go to LOCKED.
- LOCKED: on rise, produce a measurement. On mismatch, go to MEAS and set match count = 0.

Measurement timing:
- Registered one cycle after the rise-detect cycle: period <= cnt, high_len <= hi_cap, symmetric, meas_valid = 1.
- locked is updated on that same cycle; it is 1 exactly when the state is LOCKED.
- If no fall occurred since the previous rise, high_len = 0.

Timeout:
- Condition: cnt == MAX_N with no rise, in any state other than IDLE.
- Response: timeout <= 1, locked <= 0, state goes to IDLE, match count = 0.
- timeout clears on the next rise, which moves the state to ARMED with no meas_valid.

Boundaries:
- A rise with cnt == MAX_N is a valid period of MAX_N; the rise wins over timeout.
- Minimum period is 2 (clk_in toggling every clk cycle): period=2, high_len=1.

Priority:
- reset > clr > rise/timeout.
- clr together with rise: the rise is discarded, outputs clear, state goes to IDLE.

Mid-operation:
- Reset or clr mid-operation drops locked and meas_valid immediately on that edge (reset is asynchronous).

Test Plan:
- Reset, drive clk_in from an even divider with N=4 (2 high/2 low), LOCK_CNT=2 -> every meas_valid shows period=4, high_len=2, symmetric=1; locked=1 with the 3rd meas_valid; no meas_valid for the first rise.
- clk_in 3 high/2 low -> period=5, high_len=3, symmetric=0, locked after 3 pulses.
- While locked at period 4, switch clk_in to divide-by-6 -> first pulse shows period=6 (a transitional high_len is allowed) with locked=0; locked=1 again once LOCK_CNT further matching measurements are seen.
- MAX_N=16: hold clk_in low after a rise -> timeout=1 exactly when cnt reaches 16, locked=0. Restart clk_in -> timeout=0 at the first rise; the first meas_valid comes at the second rise.
- MAX_N=16, period exactly 16 (8/8) -> period=16, timeout stays 0. clk_in toggling every clk -> period=2, high_len=1.
- Assert clr (and, in a separate run, rst_n=0) while locked -> all outputs 0 on that edge. clr coincident with a rise -> no meas_valid; re-measurement starts from IDLE.

Source files
------------

// File: rtl/clk_ratio_detector.sv
// clk_ratio_detector: measures clk_in period and high phase in clk cycles, reports symmetry, lock and timeout
module clk_ratio_detector #(
  parameter int MAX_N = 256,
  parameter int LOCK_CNT = 2,
  parameter int SYNC_STAGES = 2,
  localparam int CNT_W = $clog2(MAX_N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_len,
  output logic             meas_valid,
  output logic             symmetric,
  output logic             locked,
  output logic             timeout
);
  localparam int M_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_N);
  localparam logic [M_W-1:0] LOCK_C = M_W'(LOCK_CNT);
  typedef enum logic [1:0] {IDLE, ARMED, MEAS, LOCKED} state_t;
  state_t r_state, w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_s_d;
  logic [CNT_W-1:0] r_cnt, r_hi_cap;
  logic [M_W-1:0] r_match, w_next_match;
  logic w_s, w_rise, w_fall, w_same, w_tmo, w_meas;
  assign w_s = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_s_d;
  assign w_fall = ~w_s & r_s_d;
  assign w_same = (r_cnt == period) && (r_hi_cap == high_len);
  assign w_tmo = (r_state != IDLE) && !w_rise && (r_cnt == MAX_C);
  assign w_meas = w_rise && (r_state != IDLE);
  assign locked = (r_state == LOCKED);
  // synchronizer chain and edge-detect delay; clr deliberately leaves these alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= '0;
      r_s_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_in};
      r_s_d <= w_s;
    end
  // next state and match count; a rise always beats a coincident timeout
  always_comb begin
    w_next_state = r_state;
    w_next_match = r_match;
    if (w_rise) begin
      case (r_state)
        IDLE: w_next_state = ARMED;
        ARMED: begin
          w_next_state = MEAS;
          w_next_match = '0;
        end
        MEAS: begin
          w_next_match = w_same ? r_match + 1'b1 : '0;
          if (w_same && (r_match + 1'b1 == LOCK_C)) w_next_state = LOCKED;
        end
        default: if (!w_same) begin
          w_next_state = MEAS;
          w_next_match = '0;
        end
      endcase
    end else if (w_tmo) begin
      w_next_state = IDLE;
      w_next_match = '0;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_match <= '0;
    end else if (clr) begin
      r_state <= IDLE;
      r_match <= '0;
    end else begin
      r_state <= w_next_state;
      r_match <= w_next_match;
    end
  // cycle counter, high-phase capture, measurement outputs and sticky timeout
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_hi_cap <= '0;
      period <= '0;
      high_len <= '0;
      meas_valid <= 1'b0;
      symmetric <= 1'b0;
      timeout <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_hi_cap <= '0;
      period <= '0;
      high_len <= '0;
      meas_valid <= 1'b0;
      symmetric <= 1'b0;
      timeout <= 1'b0;
    end else begin
      r_cnt <= w_rise ? CNT_W'(1) : (r_cnt == MAX_C) ? r_cnt : r_cnt + 1'b1;
      r_hi_cap <= w_rise ? '0 : (w_fall && r_state != IDLE) ? r_cnt : r_hi_cap;
      meas_valid <= w_meas;
      if (w_meas) begin
        period <= r_cnt;
        high_len <= r_hi_cap;
        symmetric <= ({r_hi_cap, 1'b0} == {1'b0, r_cnt});
      end
      timeout <= w_rise ? 1'b0 : w_tmo ? 1'b1 : timeout;
    end
endmodule

// File: tb/tb_clk_ratio_detector.sv
// tb_clk_ratio_detector: table-driven clk_in waveforms with a measurement scoreboard plus hand-written corner cases
module tb_clk_ratio_detector;
  localparam int MAX_N = 16;
  localparam int LOCK_CNT = 2;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W = $clog2(MAX_N + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic clk_in = 1'b0;
  logic [CNT_W-1:0] period, high_len;
  logic meas_valid, symmetric, locked, timeout;
  int checks = 0;
  int failures = 0;
  typedef struct {int hi; int lo; bit lk;} vec_t;
  typedef struct {int p; int h; bit s; bit l;} exp_t;
  vec_t tbl[$];
  exp_t exp_q[$];

  clk_ratio_detector #(.MAX_N(MAX_N), .LOCK_CNT(LOCK_CNT), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .clk_in(clk_in),
    .period(period), .high_len(high_len), .meas_valid(meas_valid),
    .symmetric(symmetric), .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_high_len"}, high_len, 0);
    chk({tag, "_meas_valid"}, meas_valid, 0);
    chk({tag, "_symmetric"}, symmetric, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic add(input int hi, input int lo, input bit lk);
    vec_t v;
    v.hi = hi;
    v.lo = lo;
    v.lk = lk;
    tbl.push_back(v);
  endtask

  task automatic put(input logic v);
    clk_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int a, input int b);
    for (int i = a; i <= b; i++) begin
      exp_t e;
      repeat (tbl[i].hi) put(1'b1);
      repeat (tbl[i].lo) put(1'b0);
      e.p = tbl[i].hi + tbl[i].lo;
      e.h = tbl[i].hi;
      e.s = (2 * tbl[i].hi == e.p);
      e.l = tbl[i].lk;
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_meas period=%0d high_len=%0d expected=none", period, high_len);
      end else begin
        e = exp_q.pop_front();
        chk("meas_period", period, e.p);
        chk("meas_high_len", high_len, e.h);
        chk("meas_symmetric", symmetric, e.s);
        chk("meas_locked", locked, e.l);
        chk("meas_timeout", timeout, 0);
      end
    end
  end

  initial begin
    int seen;
    for (int i = 0; i < 4; i++) add(2, 2, i >= 2);
    for (int i = 0; i < 4; i++) add(3, 2, i >= 2);
    for (int i = 0; i < 3; i++) add(2, 2, i >= 2);
    for (int i = 0; i < 3; i++) add(3, 3, i >= 2);
    for (int i = 0; i < 3; i++) add(1, 1, i >= 2);
    for (int i = 0; i < 3; i++) add(8, 8, i >= 2);
    add(2, 2, 0);
    add(2, 2, 0);
    add(2, 2, 1);
    add(2, 2, 1);
    for (int i = 0; i < 3; i++) add(3, 3, i >= 2);
    for (int i = 0; i < 3; i++) add(2, 2, i >= 2);
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    put(1'b0);
    put(1'b0);
    run_rows(0, 19);
    put(1'b1);
    put(1'b1);
    clk_in = 1'b0;
    seen = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (meas_valid && seen < 0) seen = i;
      if (seen >= 0 && i == seen + 15) chk("timeout_before_max", timeout, 0);
      if (seen >= 0 && i == seen + 16) begin
        chk("timeout_at_max", timeout, 1);
        chk("locked_after_timeout", locked, 0);
      end
      @(posedge clk);
      #1;
    end
    if (seen < 0 || seen > 20) begin
      checks++;
      failures++;
      $display("FAIL timeout_ref_meas seen_at=%0d expected=1", seen);
    end
    chk("timeout_sticky", timeout, 1);
    run_rows(20, 20);
    chk("timeout_cleared", timeout, 0);
    run_rows(21, 23);
    put(1'b1);
    put(1'b1);
    put(1'b0);
    put(1'b0);
    chk("locked_before_clr", locked, 1);
    clr = 1'b1;
    put(1'b0);
    clr = 1'b0;
    chk_zero("clr");
    put(1'b0);
    put(1'b1);
    put(1'b1);
    put(1'b0);
    put(1'b0);
    put(1'b1);
    put(1'b1);
    clr = 1'b1;
    put(1'b0);
    clr = 1'b0;
    chk("clr_rise_meas_valid", meas_valid, 0);
    chk("clr_rise_period", period, 0);
    chk("clr_rise_locked", locked, 0);
    put(1'b0);
    run_rows(24, 26);
    put(1'b1);
    put(1'b1);
    put(1'b0);
    put(1'b0);
    chk("locked_before_rst", locked, 1);
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    put(1'b0);
    rst_n = 1'b1;
    put(1'b0);
    put(1'b0);
    run_rows(27, 29);
    put(1'b1);
    put(1'b1);
    repeat (4) put(1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
